// File: rtl/ins_stage_sequencer.sv
// INS stage sequencer: queues IEEE-754 sensor samples in a small FIFO and
// walks each one through NSTAGE start/finish stage units, with a per-stage
// watchdog, a commit strobe for the state registers and sticky error flags.
//
// Handshake: in_data_en is a one-cycle strobe and is never back-pressured. A
// strobe that finds the FIFO full is dropped and counted, unless a pop happens
// in the same cycle. stage_start[k] is a one-cycle request to stage unit k.
// stage_finish[k] is the unit's one-cycle reply. It is honoured only while the
// sequencer sits in WAIT for that same k. Every other finish bit is ignored.
module ins_stage_sequencer #(
  parameter int DATA_W     = 32,
  parameter int NCH        = 9,
  parameter int NSTAGE     = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_data_en,
  input  logic [NCH*DATA_W-1:0]            in_data,
  input  logic [NSTAGE-1:0]                stage_finish,
  input  logic                             err_clr,
  output logic [NCH*DATA_W-1:0]            out_sample,
  output logic [NSTAGE-1:0]                stage_start,
  output logic [3:0]                       out_stage,
  output logic                             out_commit,
  output logic                             out_done,
  output logic                             out_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             out_timeout,
  output logic                             err_timeout,
  output logic                             err_overrun,
  output logic [7:0]                       drop_cnt
);

  localparam int SW = NCH * DATA_W;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_K   = 4'(NSTAGE - 1);
  localparam logic [TW-1:0] TERM_CNT = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_COMMIT = 3'd4,
    S_DONE   = 3'd5,
    S_ABORT  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      k_q, k_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sample_q;
  logic [SW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            err_timeout_q, err_overrun_q;
  logic [7:0]      drop_q;

  logic            pop;
  logic            fifo_full;
  logic            wr_en;
  logic            drop;
  logic            finish_k;
  logic            enter_abort;

  // FIFO write/drop decision; a pop in the same cycle frees the slot.
  always_comb begin
    pop       = (state_q == S_POP);
    fifo_full = (count_q == FULL_CNT);
    wr_en     = in_data_en && (!fifo_full || pop);
    drop      = in_data_en && !wr_en;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Select the finish bit of the stage currently being waited on.
  always_comb begin
    finish_k = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (k_q == 4'(i)) finish_k = stage_finish[i];
    end
  end

  // Next-state logic: stage index, watchdog counter and FSM state.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_POP;
      end
      S_POP: begin
        k_d     = 4'd0;
        state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + TW'(1);
        // A finish in the terminal-count cycle still counts as success.
        if (finish_k) begin
          if (k_q == LAST_K) begin
            state_d = S_COMMIT;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = S_START;
          end
        end else if (cnt_q == TERM_CNT) begin
          state_d = S_ABORT;
        end
      end
      S_COMMIT: state_d = S_DONE;
      S_DONE: begin
        k_d     = 4'd0;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        k_d     = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        k_d     = 4'd0;
        state_d = S_IDLE;
      end
    endcase
    enter_abort = (state_q == S_WAIT) && (state_d == S_ABORT);
  end

  // FSM, counters, FIFO pointers and the presented sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= 4'd0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sample_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        sample_q <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Sample storage; when full, a same-cycle pop reads the old head before
  // the write replaces it.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  // Sticky errors and drop counter; a set event beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      drop_q        <= 8'd0;
    end else begin
      if (enter_abort)  err_timeout_q <= 1'b1;
      else if (err_clr) err_timeout_q <= 1'b0;

      if (drop) begin
        err_overrun_q <= 1'b1;
        if (err_clr)              drop_q <= 8'd1;
        else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end else if (err_clr) begin
        err_overrun_q <= 1'b0;
        drop_q        <= 8'd0;
      end
    end
  end

  // One-hot start pulse decoded from the registered state and stage index.
  always_comb begin
    stage_start = '0;
    if (state_q == S_START) begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (k_q == 4'(i)) stage_start[i] = 1'b1;
      end
    end
  end

  assign out_sample  = sample_q;
  assign out_stage   = k_q;
  assign out_commit  = (state_q == S_COMMIT);
  assign out_done    = (state_q == S_DONE);
  assign out_timeout = (state_q == S_ABORT);
  assign out_busy    = (state_q != S_IDLE);
  assign fifo_count  = count_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_ins_stage_sequencer.sv
// Bench for ins_stage_sequencer: directed scenarios plus a randomized phase.
// A responder models the stage units, a scoreboard holds the expected outcome
// of every accepted sample, and a monitor checks each commit/done/timeout.
module tb_ins_stage_sequencer;

  localparam int DATA_W = 32;
  localparam int NCH    = 9;
  localparam int NSTAGE = 6;
  localparam int DEPTH  = 4;
  localparam int TMO    = 16;
  localparam int W      = NCH * DATA_W;
  localparam int CW     = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              in_data_en = 1'b0;
  logic [W-1:0]      in_data    = '0;
  logic [NSTAGE-1:0] stage_finish = '0;
  logic              err_clr    = 1'b0;
  logic [W-1:0]      out_sample;
  logic [NSTAGE-1:0] stage_start;
  logic [3:0]        out_stage;
  logic              out_commit, out_done, out_busy, out_timeout;
  logic [CW-1:0]     fifo_count;
  logic              err_timeout, err_overrun;
  logic [7:0]        drop_cnt;

  ins_stage_sequencer #(
    .DATA_W(DATA_W), .NCH(NCH), .NSTAGE(NSTAGE), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_data_en(in_data_en), .in_data(in_data),
    .stage_finish(stage_finish), .err_clr(err_clr), .out_sample(out_sample),
    .stage_start(stage_start), .out_stage(out_stage), .out_commit(out_commit),
    .out_done(out_done), .out_busy(out_busy), .fifo_count(fifo_count),
    .out_timeout(out_timeout), .err_timeout(err_timeout), .err_overrun(err_overrun),
    .drop_cnt(drop_cnt)
  );

  // ---------------- scoreboard state ----------------
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];       // expected sample of each accepted strobe
  int           exp_kind_q[$];  // -1: completes; s: hangs at stage s
  int           hang_q[$];      // responder copy of the hang plan
  int           exp_next = 0;   // next stage index the monitor expects
  int           start_cyc[NSTAGE];
  int           commit_cyc = 0, done_cyc = 0, timeout_cyc = 0, last_fin_cyc = 0;
  int           done_cnt = 0, timeout_cnt = 0;
  bit           prev_commit = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_wide(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none (cycle %0d)", name, cyc);
  endtask

  function automatic int onehot_idx(input logic [NSTAGE-1:0] v);
    int r = -1;
    for (int i = 0; i < NSTAGE; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- stage-unit responder ----------------
  int resp_delay = 3;     // 0 selects a random 1..4 cycle reply
  bit resp_noise = 1'b0;  // drive finishes that must be ignored
  bit resp_pending = 1'b0;
  int resp_cnt = 0, resp_stage = 0, cur_hang = -1, r_idx = 0;
  logic [NSTAGE-1:0] r_fin;

  always @(negedge clk) begin
    r_fin = '0;
    if (rst) begin
      resp_pending = 1'b0;
      cur_hang     = -1;
    end else begin
      if (resp_pending) begin
        if (resp_cnt <= 1) begin
          r_fin[resp_stage] = 1'b1;
          resp_pending = 1'b0;
          if (resp_stage == NSTAGE - 1) last_fin_cyc = cyc;
        end else begin
          resp_cnt--;
          if (resp_noise) r_fin[(resp_stage + 1) % NSTAGE] = 1'b1;
        end
      end
      if (|stage_start) begin
        r_idx = onehot_idx(stage_start);
        check("resp_idle_at_start", {63'd0, resp_pending}, 64'd0);
        if (r_idx == 0) cur_hang = (hang_q.size() != 0) ? hang_q.pop_front() : -1;
        if (resp_noise && r_idx >= 0) r_fin[r_idx] = 1'b1;  // finish during START
        if (r_idx >= 0 && r_idx != cur_hang) begin
          resp_pending = 1'b1;
          resp_stage   = r_idx;
          resp_cnt     = (resp_delay == 0) ? int'($urandom_range(1, 4)) : resp_delay;
        end
      end
    end
    stage_finish = r_fin;
  end

  // ---------------- monitor ----------------
  int           m_idx, m_kind;
  logic [W-1:0] m_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_commit = 1'b0;
      exp_next    = 0;
    end else begin
      if (|stage_start) begin
        m_idx = onehot_idx(stage_start);
        check("start_onehot", {63'd0, $onehot(stage_start)}, 64'd1);
        check("start_order", m_idx, exp_next);
        check("start_out_stage", out_stage, m_idx);
        if (m_idx >= 0) start_cyc[m_idx] = cyc;
        exp_next = m_idx + 1;
      end
      if (out_commit) begin
        commit_cyc = cyc;
        if (exp_kind_q.size() == 0) note_fail("commit_unexpected");
        else check("commit_kind", exp_kind_q[0], -1);
      end
      if (out_done) begin
        done_cyc = cyc;
        done_cnt++;
        exp_next = 0;
        check("done_after_commit", {63'd0, prev_commit}, 64'd1);
        if (exp_kind_q.size() == 0) note_fail("done_unexpected");
        else begin
          m_kind = exp_kind_q.pop_front();
          m_data = exp_q.pop_front();
          check("done_kind", m_kind, -1);
          check_wide("done_sample", out_sample, m_data);
        end
      end
      if (out_timeout) begin
        timeout_cyc = cyc;
        timeout_cnt++;
        exp_next = 0;
        if (exp_kind_q.size() == 0) note_fail("timeout_unexpected");
        else begin
          m_kind = exp_kind_q.pop_front();
          m_data = exp_q.pop_front();
          check("timeout_stage", out_stage, m_kind);
          check_wide("timeout_sample", out_sample, m_data);
        end
      end
      prev_commit = out_commit;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] d, input int hang, input bit accept, input bit clr);
    in_data    = d;
    in_data_en = 1'b1;
    err_clr    = clr;
    if (accept) begin
      exp_q.push_back(d);
      exp_kind_q.push_back(hang);
      hang_q.push_back(hang);
    end
    @(negedge clk);
    in_data_en = 1'b0;
    err_clr    = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_sample();
    logic [W-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*DATA_W +: DATA_W] = $urandom();
    return r;
  endfunction

  task automatic wait_started(input int stage, input string name);
    int n = 0;
    while (exp_next <= stage && n < 200) begin @(negedge clk); n++; end
    check(name, {63'd0, exp_next > stage}, 64'd1);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_kind_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    check(name, exp_kind_q.size(), 0);
    repeat (3) @(negedge clk);
    check({name, "_idle"}, {63'd0, out_busy}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [W-1:0] ones;
  int c0, d0, t0, n, sent;
  bit any_hang;

  initial begin
    for (int c = 0; c < NCH; c++) ones[c*DATA_W +: DATA_W] = 32'h3f800000;

    // Reset values.
    @(negedge clk);
    check("rst_busy", {63'd0, out_busy}, 64'd0);
    check("rst_start", stage_start, 0);
    check("rst_stage", out_stage, 0);
    check("rst_fifo", fifo_count, 0);
    check("rst_errs", {err_timeout, err_overrun, out_commit, out_done, out_timeout}, 0);
    check("rst_drop", drop_cnt, 0);
    check_wide("rst_sample", out_sample, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single sample, each finish 3 cycles after its start.
    resp_delay = 3;
    c0 = cyc;
    d0 = done_cnt;
    send(ones, -1, 1'b1, 1'b0);
    n = 0;
    while (done_cnt == d0 && n < 200) begin @(negedge clk); n++; end
    check("t1_done_seen", done_cnt, d0 + 1);
    check("t1_start0_latency", start_cyc[0], c0 + 3);
    check("t1_finish_delay", last_fin_cyc, start_cyc[NSTAGE-1] + 3);
    check("t1_commit_latency", commit_cyc, last_fin_cyc + 1);
    check("t1_done_latency", done_cyc, last_fin_cyc + 2);
    n = 0;
    while (cyc < last_fin_cyc + 3 && n < 10) begin @(negedge clk); n++; end
    check("t1_idle_latency", {63'd0, out_busy}, 64'd0);
    check("t1_fifo_empty", fifo_count, 0);
    check("t1_stage_idle", out_stage, 0);

    // Wrong-bit finishes in WAIT and finishes during START are ignored.
    resp_noise = 1'b1;
    send(rand_sample(), -1, 1'b1, 1'b0);
    drain(300, "t2_drain");
    for (int k = 0; k < NSTAGE - 1; k++)
      check("t2_start_spacing", start_cyc[k+1], start_cyc[k] + 4);
    check("t2_commit_latency", commit_cyc, last_fin_cyc + 1);
    resp_noise = 1'b0;

    // Stage 2 never finishes; the queued sample runs afterwards from stage 0.
    t0 = timeout_cnt;
    send(rand_sample(), 2, 1'b1, 1'b0);
    send(rand_sample(), -1, 1'b1, 1'b0);
    n = 0;
    while (timeout_cnt == t0 && n < 300) begin @(negedge clk); n++; end
    check("t3_timeout_seen", timeout_cnt, t0 + 1);
    check("t3_timeout_latency", timeout_cyc, start_cyc[2] + 1 + TMO);
    check("t3_err_timeout", {63'd0, err_timeout}, 64'd1);
    drain(300, "t3_drain");
    check("t3_next_start0", start_cyc[0], timeout_cyc + 3);

    // Overrun: five strobes while the FIFO is empty and the FSM is stalled.
    send(rand_sample(), 0, 1'b1, 1'b0);
    wait_started(0, "t4_started");
    for (int i = 0; i < 4; i++) send(rand_sample(), -1, 1'b1, 1'b0);
    send(rand_sample(), -1, 1'b0, 1'b0);
    check("t4_fifo_full", fifo_count, DEPTH);
    check("t4_err_overrun", {63'd0, err_overrun}, 64'd1);
    check("t4_drop_cnt", drop_cnt, 1);
    drain(800, "t4_drain");

    // Reset mid-WAIT at stage 3 with two samples queued.
    send(rand_sample(), 3, 1'b1, 1'b0);
    send(rand_sample(), -1, 1'b1, 1'b0);
    send(rand_sample(), -1, 1'b1, 1'b0);
    wait_started(3, "t5_started");
    repeat (2) @(negedge clk);
    check("t5_fifo_queued", fifo_count, 2);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", {63'd0, out_busy}, 64'd0);
    check("t5_rst_fifo", fifo_count, 0);
    check("t5_rst_stage", out_stage, 0);
    check("t5_rst_start", stage_start, 0);
    check("t5_rst_flags", {err_timeout, err_overrun, out_commit, out_done, out_timeout}, 0);
    check("t5_rst_drop", drop_cnt, 0);
    check_wide("t5_rst_sample", out_sample, '0);
    exp_q.delete();
    exp_kind_q.delete();
    hang_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_no_done", done_cnt, d0);
    send(rand_sample(), -1, 1'b1, 1'b0);
    drain(300, "t5_drain");

    // err_clr coinciding with a drop, then err_clr alone.
    send(rand_sample(), 0, 1'b1, 1'b0);
    wait_started(0, "t6_started");
    for (int i = 0; i < 4; i++) send(rand_sample(), -1, 1'b1, 1'b0);
    send(rand_sample(), -1, 1'b0, 1'b1);
    check("t6_overrun_set_wins", {63'd0, err_overrun}, 64'd1);
    check("t6_drop_set_wins", drop_cnt, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t6_overrun_cleared", {63'd0, err_overrun}, 64'd0);
    check("t6_drop_cleared", drop_cnt, 0);
    drain(800, "t6_drain");

    // Randomized traffic that never overfills the FIFO.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t7_err_timeout_clr", {63'd0, err_timeout}, 64'd0);
    resp_delay = 0;
    resp_noise = 1'b1;
    any_hang   = 1'b0;
    sent = 0;
    n = 0;
    while (sent < 40 && n < 20000) begin
      if (exp_kind_q.size() < DEPTH && $urandom_range(0, 3) == 0) begin
        int h;
        h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NSTAGE - 1)) : -1;
        if (h >= 0) any_hang = 1'b1;
        send(rand_sample(), h, 1'b1, 1'b0);
        sent++;
      end else begin
        @(negedge clk);
      end
      n++;
    end
    check("t7_all_issued", sent, 40);
    drain(4000, "t7_drain");
    check("t7_err_timeout", {63'd0, err_timeout}, {63'd0, any_hang});
    check("t7_no_overrun", {63'd0, err_overrun}, 64'd0);
    check("t7_no_drops", drop_cnt, 0);
    check("t7_fifo_empty", fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "time limit");
  end

endmodule
